// File: rtl/lane_pkg.sv
// Shared lane definitions: the alignment/idle symbol and the lane FSM state
// encoding. States are one-hot so they line up with the un-striping FSM.
package lane_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [2:0] {
    SEARCH   = 3'b001,
    ALIGNING = 3'b010,
    ALIGNED  = 3'b100
  } lane_state_e;

endpackage

// File: rtl/s2p_shift_reg.sv
// Serial-in / parallel-out shifter. The window is the most recent WIDTH bits
// including the bit on data_in right now (MSB first). The last bit of a byte
// can therefore be compared on the same edge that samples it.
module s2p_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  output logic [WIDTH-1:0] window
);

  // Only WIDTH-1 history bits are stored. The newest bit comes straight from data_in.
  logic [WIDTH-2:0] hist;

  assign window = {hist, data_in};

  // Shift one bit in every cycle. Reset clears the history so stale bits
  // cannot form a false COM after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= window[WIDTH-2:0];
  end

endmodule

// File: rtl/serial_to_parallel_lane.sv
// Per-lane deserializer. It finds byte alignment from COM symbols and then
// presents one byte per WIDTH bit-clocks on data_out/valid_out.
// COM symbols are idle fill and are never flagged valid.
// Optional build macro: S2P_COM_COUNT_EN adds a com_count output that counts
// COMs received at byte boundaries while locked.
//
// Output timing: data_out, valid_out (and com_count) change only on the
// boundary edge, which is the edge that samples the last bit of a byte.
// They then hold for WIDTH cycles.
module serial_to_parallel_lane #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL  = WIDTH'(lane_pkg::COM_SYMBOL),
  parameter int               ALIGN_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
`ifdef S2P_COM_COUNT_EN
  ,
  output logic [15:0]      com_count
`endif
);

  import lane_pkg::*;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_CNT = CW'(ALIGN_COUNT);

  logic [WIDTH-1:0] window;
  lane_state_e      state, state_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [CW-1:0]    com_cnt, com_cnt_next;
  logic             is_com;
  logic             boundary;
  logic             capture;

  s2p_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk_8f),
    .rst     (reset),
    .data_in (data_in),
    .window  (window)
  );

  assign is_com   = (window == COM_SYMBOL);
  assign boundary = (bit_cnt == LAST_BIT);
  assign active   = (state == ALIGNED);

  // State and alignment counters.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      bit_cnt <= '0;
      com_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      com_cnt <= com_cnt_next;
    end
  end

  // Next-state logic.
  // SEARCH checks the window at every bit position.
  // ALIGNING and ALIGNED check only at byte boundaries.
  // Once ALIGNED, the lane stays locked until reset.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    com_cnt_next = com_cnt;
    capture      = 1'b0;
    unique case (state)
      SEARCH: begin
        bit_cnt_next = '0;
        if (is_com) begin
          com_cnt_next = CW'(1);
          state_next   = (ALIGN_COUNT == 1) ? ALIGNED : ALIGNING;
        end
      end
      ALIGNING: begin
        bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
        if (boundary) begin
          if (is_com) begin
            if (com_cnt >= LOCK_CNT - 1'b1) begin
              com_cnt_next = LOCK_CNT;
              state_next   = ALIGNED;
            end else begin
              com_cnt_next = com_cnt + 1'b1;
            end
          end else begin
            com_cnt_next = '0;
            state_next   = SEARCH;
          end
        end
      end
      ALIGNED: begin
        bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
        capture      = boundary;
      end
      default: begin
        state_next   = SEARCH;
        bit_cnt_next = '0;
        com_cnt_next = '0;
      end
    endcase
  end

  // Output byte register.
  // It loads only at boundaries while locked, so the COM that completes
  // lock is never presented.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (capture) begin
      data_out  <= window;
      valid_out <= !is_com;
    end
  end

`ifdef S2P_COM_COUNT_EN
  // Saturating count of idle COMs seen at boundaries while locked.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset)                              com_count <= '0;
    else if (capture && is_com && com_count != 16'hFFFF) com_count <= com_count + 16'd1;
  end
`endif

endmodule
